// File: rtl/dp_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_mem_pkg
// Description : Shared types, sizing defaults and port-B index helper for
//               the dual-port memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEPTH_DEFAULT = 1024;
    localparam int IDX_W_DEFAULT = $clog2(DEPTH_DEFAULT);

    // Port B may present byte addresses; the word index drops the byte lane bits.
    function automatic logic [31:0] calc_idx_b(input logic [31:0] address,
                                               input logic        byte_mode);
        return byte_mode ? {2'b00, address[31:2]} : address;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dp_ram_core.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram_core
// Description : True dual-port word storage, read-first, port B wins on a
//               same-word write collision. No reset, no range checking.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_ram_core #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we_a,
    input  logic [IDX_W-1:0] i_addr_a,
    input  logic [31:0]      i_wdata_a,
    output logic [31:0]      o_rdata_a,
    input  logic             i_we_b,
    input  logic [IDX_W-1:0] i_addr_b,
    input  logic [31:0]      i_wdata_b,
    output logic [31:0]      o_rdata_b
);

    logic [31:0] r_mem [DEPTH];

    // Port B is written last so its value survives a same-word collision.
    always_ff @(posedge clk) begin
        if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
        if (i_we_b) r_mem[i_addr_b] <= i_wdata_b;
    end

    // Read data reflects pre-edge contents; the caller registers it.
    assign o_rdata_a = r_mem[i_addr_a];
    assign o_rdata_b = r_mem[i_addr_b];

endmodule
`default_nettype wire

// File: rtl/dp_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dp_mem_responder
// Description : Dual-port memory responder with post-reset clear sweep,
//               range checking, registered read data and error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_mem_responder
    import dp_mem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter bit ADDR_B_BYTE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address_a,
    input  logic [31:0] data_a,
    input  logic        wren_a,
    input  logic        rden_a,
    output logic [31:0] q_a,
    input  logic [31:0] address_b,
    input  logic [31:0] data_b,
    input  logic        wren_b,
    input  logic        rden_b,
    output logic [31:0] q_b,
    output logic        ready,
    output logic        oob_err
);

    localparam int               IDX_W   = $clog2(DEPTH);
    localparam logic [31:0]      c_depth = 32'(DEPTH);
    localparam logic [IDX_W-1:0] c_last  = IDX_W'(DEPTH - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_clr_cnt;
    logic [31:0]      r_q_a;
    logic [31:0]      r_q_b;
    logic             r_ready;
    logic             r_oob_err;

    logic [31:0]      w_idx_a;
    logic [31:0]      w_idx_b;
    logic             w_a_in;
    logic             w_b_in;
    logic             w_serving;
    logic             w_we_a;
    logic [IDX_W-1:0] w_addr_a;
    logic [31:0]      w_wdata_a;
    logic             w_we_b;
    logic [31:0]      w_rd_a;
    logic [31:0]      w_rd_b;
    logic             w_oob;

    assign w_idx_a   = address_a;
    assign w_idx_b   = calc_idx_b(address_b, ADDR_B_BYTE);
    // Full-width compare so large addresses never alias onto low words.
    assign w_a_in    = (w_idx_a < c_depth);
    assign w_b_in    = (w_idx_b < c_depth);
    assign w_serving = (r_state == READY);

    // Port A write path is borrowed by the clear sweep until READY.
    assign w_we_a    = w_serving ? (wren_a & w_a_in) : 1'b1;
    assign w_addr_a  = w_serving ? w_idx_a[IDX_W-1:0] : r_clr_cnt;
    assign w_wdata_a = w_serving ? data_a : 32'h0;
    assign w_we_b    = w_serving & wren_b & w_b_in;

    assign w_oob = (~w_a_in & (wren_a | rden_a)) | (~w_b_in & (wren_b | rden_b));

    dp_ram_core #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_core (
        .clk       (clk),
        .i_we_a    (w_we_a),
        .i_addr_a  (w_addr_a),
        .i_wdata_a (w_wdata_a),
        .o_rdata_a (w_rd_a),
        .i_we_b    (w_we_b),
        .i_addr_b  (w_idx_b[IDX_W-1:0]),
        .i_wdata_b (data_b),
        .o_rdata_b (w_rd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_q_a     <= 32'h0;
            r_q_b     <= 32'h0;
            r_ready   <= 1'b0;
            r_oob_err <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    r_oob_err <= 1'b0;
                    if (r_clr_cnt == c_last) begin
                        r_state <= READY;
                        r_ready <= 1'b1;
                    end
                end
                READY: begin
                    if (rden_a) r_q_a <= w_a_in ? w_rd_a : 32'h0;
                    if (rden_b) r_q_b <= w_b_in ? w_rd_b : 32'h0;
                    r_oob_err <= w_oob;
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    assign q_a     = r_q_a;
    assign q_b     = r_q_b;
    assign ready   = r_ready;
    assign oob_err = r_oob_err;

endmodule
`default_nettype wire

// File: doc/dp_mem_responder.md
# dp_mem_responder

Memory-side responder for the processor's dual-port memory interface: services port A (instruction fetch, read-only in practice) and port B (data load/store) against a single word-organised storage array. After every reset it sweeps the array to zero before accepting accesses. It resolves same-word collisions, range-checks addresses and drives registered read data back to the interface.

## Interface
Parameters:
- DEPTH, 1024 — number of 32-bit words; power of two, ≥ 4.
- ADDR_B_BYTE, 1 — 1: address_b is a byte address, word index = address_b >> 2; 0: address_b is a word index.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- address_a  in  32  port A word index.
- data_a  in  32  port A write data.
- wren_a  in  1  port A write enable.
- rden_a  in  1  port A read enable.
- q_a  out  32  port A registered read data.
- address_b  in  32  port B address, byte or word per ADDR_B_BYTE.
- data_b  in  32  port B write data.
- wren_b  in  1  port B write enable.
- rden_b  in  1  port B read enable.
- q_b  out  32  port B registered read data.
- ready  out  1  high once the post-reset clear sweep has completed.
- oob_err  out  1  one-cycle pulse on an out-of-range access on either port.

## Operation
- Reset: rst_n low asserts asynchronously and forces:
  - state CLEAR, clear counter 0;
  - q_a = 0, q_b = 0, ready = 0, oob_err = 0.
  - Array contents are not reset; the sweep clears them.
- States:
  - CLEAR: writes 0 to word clr_cnt each cycle and increments clr_cnt. When clr_cnt == DEPTH-1 is written, go to READY.
  - READY: normal service. Terminal until the next reset.
- In CLEAR:
  - wren_a and wren_b are ignored.
  - rden_a and rden_b are ignored; q_a and q_b hold 0.
  - oob_err stays 0.
- Index: idx_a = address_a; idx_b = ADDR_B_BYTE ? address_b >> 2 : address_b.
  - An access is in range when idx < DEPTH, compared on the full 32-bit value with no truncation or wrap.
  - Out-of-range write: dropped.
  - Out-of-range read: q updates to 0.
  - Any out-of-range access with wren or rden high pulses oob_err on the following cycle.
- Reads:
  - q_x updates only on cycles with rden_x high; otherwise q_x holds its last value.
  - Read-first: a read of a word written in the same cycle, from either port, returns the old contents.
- Writes:
  - Commit on the rising edge where wren_x is high and the index is in range.
  - wren and rden high together on one port: the write commits and the read returns the old data.
- Collision: both ports write the same word in the same cycle → port B data is stored and port A's write is lost. No error is flagged.

## Timing
- Read latency 1: rden_x sampled at edge k, q_x valid after edge k and stable until the next edge with rden_x high.
- Write latency 1: data is visible to a read issued at edge k+1 or later.
- ready rises after edge DEPTH following rst_n deassertion; for DEPTH = 1024, the first serviced access is at edge 1025.
- oob_err is high for exactly the one cycle following the offending edge; back-to-back violations give a continuous high.
- Reset asserted mid-sweep or mid-access restarts the sweep from word 0. A read in flight is discarded and q returns 0 immediately.

## Structure
- Shared package dp_mem_pkg holds:
  - state enum {CLEAR, READY};
  - DEPTH default and derived IDX_W = $clog2(DEPTH);
  - a function computing idx_b from address_b and ADDR_B_BYTE.
- Sub-module dp_ram_core: pure true-dual-port storage with per-port we, read-first semantics and port-B-wins collision. Contains no reset and no range logic.
- The top module holds the clear FSM and counter, the write-port mux (clear vs port A), range checks, q output registers and oob_err.

## Test plan
- Release rst_n, hold rden_b = 1 at word 5 → q_b = 0 throughout, ready rises exactly DEPTH edges after release, q_b = 0 after.
- READY, write 0xDEADBEEF via B to byte address 0x10; next cycle rden_a at word 4 → q_a = 0xDEADBEEF one cycle later.
- Same edge: wren_a data 0x1111 and wren_b data 0x2222, both to word 7; then read → 0x2222.
- Word 3 holds 0xA; same edge: write 0xB via A and read via B at word 3 → q_b = 0xA; next read → 0xB.
- rden_b with address_b = DEPTH*4 → q_b = 0 and oob_err pulses one cycle. wren_a to address DEPTH → word 0 is unchanged.
- Assert rst_n low at sweep count 300 and mid-READY with q_b = 0x55 → q_b = 0 and ready = 0 immediately; the full DEPTH-cycle sweep repeats.
